// File: rtl/load_use_hazard_ctrl_pkg.sv
// Shared definitions for the load-use hazard controller.
// State encoding and register-file constants.
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } hzState_e;

  localparam int ZERO_REG = 0;

endpackage

// File: rtl/load_use_hazard_ctrl_if.sv
// Bundle between the hazard controller and the pipeline.
// master: hazard unit side; slave: pipeline side.
interface load_use_hazard_ctrl_if #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
);

  logic                      mem_read_ex;
  logic [REG_AW-1:0]         reg_write_addr_ex;
  logic [NUM_SRC*REG_AW-1:0] src_addr_id;
  logic [NUM_SRC-1:0]        src_used_id;
  logic                      branch_taken_ex;
  logic                      dmem_req_mem;
  logic                      dmem_ready;
  logic                      pc_write;
  logic                      ifid_write;
  logic                      idex_bubble;
  logic                      ifid_flush;
  logic                      pipe_freeze;
  logic [CNT_W-1:0]          stall_cycles;

  modport master (
    input  mem_read_ex,
    input  reg_write_addr_ex,
    input  src_addr_id,
    input  src_used_id,
    input  branch_taken_ex,
    input  dmem_req_mem,
    input  dmem_ready,
    output pc_write,
    output ifid_write,
    output idex_bubble,
    output ifid_flush,
    output pipe_freeze,
    output stall_cycles
  );

  modport slave (
    output mem_read_ex,
    output reg_write_addr_ex,
    output src_addr_id,
    output src_used_id,
    output branch_taken_ex,
    output dmem_req_mem,
    output dmem_ready,
    input  pc_write,
    input  ifid_write,
    input  idex_bubble,
    input  ifid_flush,
    input  pipe_freeze,
    input  stall_cycles
  );

endinterface

// File: rtl/hazard_src_match.sv
// Compares the EX load destination against every used ID source.
// Register 0 never creates a hazard.
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2
) (
  input  logic                      memRead,
  input  logic [REG_AW-1:0]         rdAddr,
  input  logic [NUM_SRC*REG_AW-1:0] srcAddr,
  input  logic [NUM_SRC-1:0]        srcUsed,
  output logic                      hz
);

  logic anyMatch;

  always_comb begin
    anyMatch = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (srcUsed[i] &&
          srcAddr[i*REG_AW +: REG_AW] == rdAddr)
        anyMatch = 1'b1;
    end
  end

  assign hz = memRead &&
              (rdAddr != REG_AW'(ZERO_REG)) &&
              anyMatch;

endmodule

// File: rtl/load_use_hazard_ctrl.sv
// Load-use stall FSM, memory freeze and branch flush control.
// Outputs are combinational; state and counters are registered.
module load_use_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW         = 5,
  parameter int NUM_SRC        = 2,
  parameter int LOAD_STALL_CYC = 1,
  parameter int CNT_W          = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  load_use_hazard_ctrl_if.master bus
);

  localparam int CW = $clog2(LOAD_STALL_CYC + 1);
  localparam logic [CW-1:0] CNT_INIT =
    CW'(LOAD_STALL_CYC - 1);

  hzState_e         state;
  logic [CW-1:0]    cnt;
  logic [CNT_W-1:0] stallCnt;

  logic hz;
  logic mw;
  logic pcWrite;
  logic ifidWrite;
  logic idexBubble;
  logic ifidFlush;
  logic pipeFreeze;

  hazard_src_match #(
    .REG_AW  (REG_AW),
    .NUM_SRC (NUM_SRC)
  ) uMatch (
    .memRead (bus.mem_read_ex),
    .rdAddr  (bus.reg_write_addr_ex),
    .srcAddr (bus.src_addr_id),
    .srcUsed (bus.src_used_id),
    .hz      (hz)
  );

  assign mw = bus.dmem_req_mem && !bus.dmem_ready;

  always_comb begin
    pcWrite    = 1'b1;
    ifidWrite  = 1'b1;
    idexBubble = 1'b0;
    ifidFlush  = 1'b0;
    pipeFreeze = 1'b0;
    if (rst) begin
      pcWrite = 1'b1;
    end else if (mw) begin
      pipeFreeze = 1'b1;
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
    end else if (bus.branch_taken_ex) begin
      // The instruction in ID is wrong-path too
      ifidFlush  = 1'b1;
      idexBubble = 1'b1;
    end else if ((state == RUN && hz) ||
                 state == LU_STALL) begin
      idexBubble = 1'b1;
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      cnt      <= '0;
      stallCnt <= '0;
    end else begin
      if ((pipeFreeze || (idexBubble && !ifidFlush)) &&
          stallCnt != '1)
        stallCnt <= stallCnt + 1'b1;
      if (mw) begin
        state <= state;
      end else if (bus.branch_taken_ex) begin
        state <= RUN;
        cnt   <= '0;
      end else if (state == RUN) begin
        if (hz && LOAD_STALL_CYC > 1) begin
          state <= LU_STALL;
          cnt   <= CNT_INIT;
        end
      end else begin
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1))
          state <= RUN;
      end
    end
  end

  assign bus.pc_write     = pcWrite;
  assign bus.ifid_write   = ifidWrite;
  assign bus.idex_bubble  = idexBubble;
  assign bus.ifid_flush   = ifidFlush;
  assign bus.pipe_freeze  = pipeFreeze;
  assign bus.stall_cycles = stallCnt;

endmodule

// File: tb/tb_load_use_hazard_ctrl.sv
// Directed bench for load_use_hazard_ctrl.
// Three instances share stimulus: 1 bubble, 3 bubbles, 4-bit counter.
module tb_load_use_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       memRead = 1'b0;
  logic [4:0] rd = '0;
  logic [9:0] src = '0;
  logic [1:0] used = '0;
  logic       br = 1'b0;
  logic       req = 1'b0;
  logic       rdy = 1'b1;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  load_use_hazard_ctrl_if #(.REG_AW(5), .NUM_SRC(2), .CNT_W(16)) ifA ();
  load_use_hazard_ctrl_if #(.REG_AW(5), .NUM_SRC(2), .CNT_W(16)) ifB ();
  load_use_hazard_ctrl_if #(.REG_AW(5), .NUM_SRC(2), .CNT_W(4))  ifC ();

  assign ifA.mem_read_ex       = memRead;
  assign ifA.reg_write_addr_ex = rd;
  assign ifA.src_addr_id       = src;
  assign ifA.src_used_id       = used;
  assign ifA.branch_taken_ex   = br;
  assign ifA.dmem_req_mem      = req;
  assign ifA.dmem_ready        = rdy;

  assign ifB.mem_read_ex       = memRead;
  assign ifB.reg_write_addr_ex = rd;
  assign ifB.src_addr_id       = src;
  assign ifB.src_used_id       = used;
  assign ifB.branch_taken_ex   = br;
  assign ifB.dmem_req_mem      = req;
  assign ifB.dmem_ready        = rdy;

  assign ifC.mem_read_ex       = memRead;
  assign ifC.reg_write_addr_ex = rd;
  assign ifC.src_addr_id       = src;
  assign ifC.src_used_id       = used;
  assign ifC.branch_taken_ex   = br;
  assign ifC.dmem_req_mem      = req;
  assign ifC.dmem_ready        = rdy;

  load_use_hazard_ctrl #(
    .REG_AW(5), .NUM_SRC(2), .LOAD_STALL_CYC(1), .CNT_W(16)
  ) uA (.clk(clk), .rst(rst), .bus(ifA.master));

  load_use_hazard_ctrl #(
    .REG_AW(5), .NUM_SRC(2), .LOAD_STALL_CYC(3), .CNT_W(16)
  ) uB (.clk(clk), .rst(rst), .bus(ifB.master));

  load_use_hazard_ctrl #(
    .REG_AW(5), .NUM_SRC(2), .LOAD_STALL_CYC(1), .CNT_W(4)
  ) uC (.clk(clk), .rst(rst), .bus(ifC.master));

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    memRead = 1'b0;
    rd      = '0;
    src     = '0;
    used    = '0;
    br      = 1'b0;
    req     = 1'b0;
    rdy     = 1'b1;
  endtask

  task automatic hazard();
    memRead = 1'b1;
    rd      = 5'd8;
    src     = {5'd3, 5'd8};
    used    = 2'b11;
  endtask

  task automatic doReset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    // Reset forces run outputs even with hazard and memory wait present
    hazard();
    req = 1'b1;
    rdy = 1'b0;
    #1;
    chk("rst_pc", ifA.pc_write, 1);
    chk("rst_ifid", ifA.ifid_write, 1);
    chk("rst_bub", ifA.idex_bubble, 0);
    chk("rst_frz", ifA.pipe_freeze, 0);
    chk("rst_fl", ifA.ifid_flush, 0);
    tick();
    tick();
    doReset();
    chk("rst_cnt", ifA.stall_cycles, 0);
    chk("rst_run_pc", ifB.pc_write, 1);

    // Basic load-use, one bubble
    hazard();
    #1;
    chk("lu_bub", ifA.idex_bubble, 1);
    chk("lu_pc", ifA.pc_write, 0);
    chk("lu_ifid", ifA.ifid_write, 0);
    chk("lu_fl", ifA.ifid_flush, 0);
    tick();
    idle();
    #1;
    chk("lu_after_pc", ifA.pc_write, 1);
    chk("lu_after_bub", ifA.idex_bubble, 0);
    chk("lu_cnt", ifA.stall_cycles, 1);

    // Excluded matches
    doReset();
    memRead = 1'b1;
    rd      = 5'd0;
    src     = {5'd3, 5'd0};
    used    = 2'b11;
    #1;
    chk("x0_pc", ifA.pc_write, 1);
    chk("x0_bub", ifA.idex_bubble, 0);
    rd   = 5'd8;
    src  = {5'd3, 5'd8};
    used = 2'b10;
    #1;
    chk("unused_pc", ifA.pc_write, 1);
    chk("unused_bub", ifA.idex_bubble, 0);
    src = {5'd8, 5'd3};
    #1;
    chk("op1_bub", ifA.idex_bubble, 1);
    memRead = 1'b0;
    #1;
    chk("noload_pc", ifA.pc_write, 1);

    // Three bubbles with two freeze cycles in the middle
    doReset();
    hazard();
    #1;
    chk("mb_c0_bub", ifB.idex_bubble, 1);
    tick();
    idle();
    #1;
    chk("mb_c1_bub", ifB.idex_bubble, 1);
    chk("mb_c1_pc", ifB.pc_write, 0);
    tick();
    req = 1'b1;
    rdy = 1'b0;
    #1;
    chk("mb_c2_frz", ifB.pipe_freeze, 1);
    chk("mb_c2_bub", ifB.idex_bubble, 0);
    chk("mb_c2_pc", ifB.pc_write, 0);
    tick();
    chk("mb_c3_frz", ifB.pipe_freeze, 1);
    tick();
    rdy = 1'b1;
    #1;
    chk("mb_c4_frz", ifB.pipe_freeze, 0);
    chk("mb_c4_bub", ifB.idex_bubble, 1);
    tick();
    idle();
    #1;
    chk("mb_c5_pc", ifB.pc_write, 1);
    chk("mb_c5_bub", ifB.idex_bubble, 0);
    chk("mb_cnt", ifB.stall_cycles, 5);

    // Branch wins over a load-use hazard
    doReset();
    hazard();
    br = 1'b1;
    #1;
    chk("br_fl", ifB.ifid_flush, 1);
    chk("br_pc", ifB.pc_write, 1);
    chk("br_ifid", ifB.ifid_write, 1);
    chk("br_bub", ifB.idex_bubble, 1);
    tick();
    idle();
    #1;
    chk("br_next_pc", ifB.pc_write, 1);
    chk("br_next_bub", ifB.idex_bubble, 0);
    chk("br_cnt", ifB.stall_cycles, 0);

    // Branch aborts a pending multi-cycle stall
    hazard();
    tick();
    idle();
    #1;
    chk("ab_stall_bub", ifB.idex_bubble, 1);
    br = 1'b1;
    #1;
    chk("ab_fl", ifB.ifid_flush, 1);
    chk("ab_pc", ifB.pc_write, 1);
    tick();
    br = 1'b0;
    #1;
    chk("ab_next_pc", ifB.pc_write, 1);
    chk("ab_next_bub", ifB.idex_bubble, 0);
    chk("ab_cnt", ifB.stall_cycles, 1);

    // Reset pulsed in the middle of a stall
    doReset();
    hazard();
    tick();
    idle();
    #1;
    chk("rm_stall", ifB.idex_bubble, 1);
    rst = 1'b1;
    #1;
    chk("rm_rst_pc", ifB.pc_write, 1);
    chk("rm_rst_bub", ifB.idex_bubble, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rm_pc", ifB.pc_write, 1);
    chk("rm_bub", ifB.idex_bubble, 0);
    chk("rm_cnt", ifB.stall_cycles, 0);

    // Counter saturation on the 4-bit instance
    doReset();
    req = 1'b1;
    rdy = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_frz", ifC.pipe_freeze, 1);
    chk("sat_c", ifC.stall_cycles, 4'hF);
    chk("sat_a", ifA.stall_cycles, 20);
    idle();
    tick();
    chk("sat_hold", ifC.stall_cycles, 4'hF);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
